fetch_queue: RTL and testbench

- Parametrised successor to the single-entry IF stage: a prefetching fetch unit.
- Keeps up to MAX_OUTST in-order inst SRAM-like requests in flight and buffers returned instructions in a DEPTH-entry queue toward decode (valid/ready).
- Redirects (exception, ERET, branch) flush the queue and discard stale in-flight responses, so decode never sees a wrong-path fetch.
- Sits between the PC/redirect logic and id_stage.

---
 rtl/fetch_queue_pkg.sv | 32 +++
 rtl/fq_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 176 +++++++++++++++++
 tb/tb_fetch_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared types and constants for the prefetching fetch unit.
//                The queue entry layout is {adel, inst, pc}.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // Width of one instruction-queue entry: adel(1) + inst(32) + pc(32).
    localparam int unsigned c_entry_wd     = 65;
    // Reset vector, used as the default first fetch address.
    localparam logic [31:0] c_reset_vector = 32'hbfc00000;

    typedef struct packed {
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [31:0] pc,
                                             input logic [31:0] inst,
                                             input logic        adel);
        fq_entry_t e;
        e.adel = adel;
        e.inst = inst;
        e.pc   = pc;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fq_fifo
//  Description : Synchronous FIFO with flush. Head entry is read directly
//                from the storage register. DEPTH must be a power of 2, >= 2.
//  Ports       : clk, resetn (async, active low), flush, push/push_data,
//                pop, head_data, count (entries stored)
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Pointers carry one extra bit so that full and empty differ.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign w_empty   = (count == '0);
    assign w_full    = (count == (AW+1)'(DEPTH));
    assign w_do_pop  = pop && !w_empty;
    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_do_push = push && (!w_full || w_do_pop);
    assign head_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Prefetching fetch unit. Keeps up to MAX_OUTST in-order
//                instruction SRAM requests in flight and buffers returned
//                instructions in a DEPTH-entry queue toward decode. Redirects
//                flush the queue and discard stale in-flight responses.
//  Ports       : clk, resetn (async, active low)
//                redirect_valid/redirect_pc : restart fetch
//                inst_sram_*                : SRAM-like instruction bus
//                out_valid/out_ready/out_pc/out_inst/out_adel : to decode
//                occupancy                  : queue entries used
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = c_reset_vector
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_sram_en,
    output logic                       inst_sram_wr,
    output logic [1:0]                 inst_sram_size,
    output logic [3:0]                 inst_sram_wen,
    output logic [31:0]                inst_sram_addr,
    output logic [31:0]                inst_sram_wdata,
    input  logic                       inst_sram_addr_ok,
    input  logic                       inst_sram_data_ok,
    input  logic [31:0]                inst_sram_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_inst,
    output logic                       out_adel,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCW = $clog2(DEPTH + 1);
    localparam int IFW = $clog2(MAX_OUTST + 1);
    localparam int SW  = OCW + 1;

    logic            r_started;
    logic [31:0]     r_req_pc;
    logic [31:0]     r_redir_pc;
    logic            r_redir_pend;
    logic            r_adel_lock;
    logic [IFW-1:0]  r_discard;

    logic [IFW-1:0]  w_inflight;
    logic [IFW-1:0]  w_live;
    logic [OCW-1:0]  w_occ;
    logic [31:0]     w_inflight_pc;
    fq_entry_t       w_head;
    fq_entry_t       w_push_entry;
    logic            w_space;
    logic            w_en;
    logic            w_accept;
    logic            w_resp;
    logic            w_drop;
    logic            w_resp_push;
    logic            w_adel_push;
    logic            w_q_push;
    logic            w_q_pop;

    // Live requests will land in the queue, so they reserve space up front.
    assign w_live   = w_inflight - r_discard;
    assign w_space  = (SW'(w_live) + SW'(w_occ)) < SW'(DEPTH);

    // Issue depends only on registered state, so a raised en cannot drop
    // before acceptance: redirects only free space or clear adel_lock, and
    // req_pc is frozen while a request is pending.
    assign w_en     = r_started && !r_adel_lock && (r_req_pc[1:0] == 2'b00) &&
                      (w_inflight < IFW'(MAX_OUTST)) && w_space;
    assign w_accept = w_en && inst_sram_addr_ok;
    // A response with nothing in flight belongs to a request from before reset.
    assign w_resp   = inst_sram_data_ok && (w_inflight != '0);
    assign w_drop   = redirect_valid || (r_discard != '0);
    assign w_resp_push = w_resp && !w_drop;

    // Misaligned PC: an ADEL entry goes in once everything older has drained,
    // which keeps it in program order behind any live responses.
    assign w_adel_push = r_started && !r_adel_lock && (r_req_pc[1:0] != 2'b00) &&
                         !r_redir_pend && !redirect_valid && (w_live == '0) &&
                         (w_occ < OCW'(DEPTH));

    assign w_q_push     = w_resp_push || w_adel_push;
    assign w_push_entry = w_adel_push ? make_entry(r_req_pc, 32'h0, 1'b1)
                                      : make_entry(w_inflight_pc, inst_sram_rdata, 1'b0);
    assign w_q_pop      = out_valid && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_started    <= 1'b0;
            r_req_pc     <= RESET_PC;
            r_redir_pc   <= '0;
            r_redir_pend <= 1'b0;
            r_adel_lock  <= 1'b0;
            r_discard    <= '0;
        end else begin
            r_started <= 1'b1;
            if (redirect_valid) begin
                // Everything still in flight after this edge is wrong-path.
                r_discard   <= w_inflight + IFW'(w_accept) - IFW'(w_resp);
                r_adel_lock <= 1'b0;
                if (w_en && !inst_sram_addr_ok) begin
                    // Pending request must stay on the bus; hold the target.
                    r_redir_pend <= 1'b1;
                    r_redir_pc   <= redirect_pc;
                end else begin
                    r_redir_pend <= 1'b0;
                    r_req_pc     <= redirect_pc;
                end
            end else begin
                r_discard <= r_discard + IFW'(w_accept && r_redir_pend)
                                       - IFW'(w_resp && (r_discard != '0));
                if (w_adel_push) r_adel_lock <= 1'b1;
                if (w_accept) begin
                    if (r_redir_pend) begin
                        r_req_pc     <= r_redir_pc;
                        r_redir_pend <= 1'b0;
                    end else begin
                        r_req_pc <= r_req_pc + 32'd4;
                    end
                end
            end
        end
    end

    fq_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTST)
    ) u_inflight (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (1'b0),
        .push      (w_accept),
        .push_data (r_req_pc),
        .pop       (w_resp),
        .head_data (w_inflight_pc),
        .count     (w_inflight)
    );

    fq_fifo #(
        .WIDTH (c_entry_wd),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (redirect_valid),
        .push      (w_q_push),
        .push_data (w_push_entry),
        .pop       (w_q_pop),
        .head_data (w_head),
        .count     (w_occ)
    );

    assign inst_sram_en    = w_en;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_addr  = {r_req_pc[31:2], 2'b00};
    assign inst_sram_wdata = 32'h0;

    assign occupancy = w_occ;
    assign out_valid = (w_occ != '0);
    assign out_pc    = out_valid ? w_head.pc   : 32'h0;
    assign out_inst  = out_valid ? w_head.inst : 32'h0;
    assign out_adel  = out_valid && w_head.adel;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue. An in-order SRAM model
//                answers bus requests; expected decode entries are queued by
//                the stimulus and compared on every out_valid/out_ready beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;

    logic        clk;
    logic        resetn;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_sram_en;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adel;
    logic [2:0]  occupancy;

    fetch_queue #(
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (32'hbfc00000)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .inst_sram_en      (inst_sram_en),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wen     (inst_sram_wen),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_adel          (out_adel),
        .occupancy         (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        adel;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t        sb[$];
    pend_t       sram_q[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    int          hs_cyc[$];

    int          cyc;
    int          n_checks;
    int          n_pass;
    int          addr_ok_pct;
    int          lat_min;
    int          lat_max;
    bit          resp_hold;
    bit          rand_ready;
    bit          check_occ;
    bit          prev_pend;
    logic [31:0] prev_addr;
    bit          last_rsp;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] pc, input logic [31:0] inst,
                                    input logic adel);
        exp_t e;
        e.adel = adel;
        e.inst = inst;
        e.pc   = pc;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // One clock: entered and left at a falling edge with inputs set.
    task automatic cycle();
        logic  acc;
        logic  rsp;
        exp_t  e;
        pend_t p;
        if (rand_ready) out_ready = ($urandom_range(0, 99) < 60);
        inst_sram_addr_ok = ($urandom_range(0, 99) < addr_ok_pct);
        rsp = !resp_hold && (sram_q.size() != 0) && (sram_q[0].due <= cyc);
        inst_sram_data_ok = rsp;
        inst_sram_rdata   = rsp ? inst_of(sram_q[0].addr) : 32'h0;
        #1;
        if (resetn && prev_pend) begin
            check("en_held", inst_sram_en, 1);
            check("addr_held", inst_sram_addr, prev_addr);
        end
        acc       = inst_sram_en && inst_sram_addr_ok;
        prev_pend = resetn && inst_sram_en && !inst_sram_addr_ok;
        prev_addr = inst_sram_addr;
        last_rsp  = rsp;
        if (rsp) void'(sram_q.pop_front());
        if (acc) begin
            p.addr = inst_sram_addr;
            p.due  = cyc + int'($urandom_range(lat_min, lat_max));
            sram_q.push_back(p);
            acc_log.push_back(inst_sram_addr);
            acc_cyc.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_out_valid", out_valid, 0);
            end else begin
                e = sb.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_inst", out_inst, e.inst);
                check("out_adel", out_adel, e.adel);
            end
        end
        if (redirect_valid) sb.delete();
        if (check_occ) check("occ_bound", occupancy <= DEPTH, 1);
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_empty(input string tag, input int max);
        int n = 0;
        while (sb.size() != 0 && n < max) begin
            cycle();
            n++;
        end
        check(tag, sb.size(), 0);
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        logic [31:0] a = start;
        for (int i = 0; i < n; i++) begin
            sb.push_back(mk_exp(a, inst_of(a), 1'b0));
            a += 32'd4;
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        prev_pend      = 1'b0;
        sram_q.delete();
        cycle();
        cycle();
        resetn = 1'b1;
        acc_log.delete();
        acc_cyc.delete();
        hs_cyc.delete();
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"}, inst_sram_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_out_inst"}, out_inst, 0);
        check({tag, "_out_adel"}, out_adel, 0);
        check({tag, "_occupancy"}, occupancy, 0);
    endtask

    initial begin
        int          n_acc;
        int          n;
        logic [31:0] tgt;

        n_checks = 0; n_pass = 0; cyc = 0;
        addr_ok_pct = 100; lat_min = 1; lat_max = 1;
        resp_hold = 0; rand_ready = 0; check_occ = 0; prev_pend = 0;
        prev_addr = 32'h0; last_rsp = 0;
        resetn = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;

        // Reset state and tie-offs.
        @(negedge clk);
        #1;
        check_all_zero("reset");
        check("wr_const", inst_sram_wr, 0);
        check("size_const", inst_sram_size, 2'b10);
        check("wen_const", inst_sram_wen, 0);
        check("wdata_const", inst_sram_wdata, 0);
        do_reset();

        // Zero-wait streaming, one instruction per cycle after fill.
        out_ready = 1'b1;
        push_seq(32'hbfc00000, 8);
        run_until_empty("stream_drain", 40);
        if (hs_cyc.size() >= 8 && acc_cyc.size() >= 1) begin
            check("fill_latency", hs_cyc[0] - acc_cyc[0], 2);
            for (int i = 1; i < 8; i++) check("stream_gap", hs_cyc[i] - hs_cyc[i-1], 1);
        end
        out_ready = 1'b0;

        // Back-pressure: exactly DEPTH accepts, then resume in order.
        do_reset();
        run_n(20);
        check("bp_accepts", acc_log.size(), 4);
        check("bp_en_low", inst_sram_en, 0);
        check("bp_occupancy", occupancy, 4);
        push_seq(32'hbfc00000, 8);
        out_ready = 1'b1;
        run_until_empty("bp_drain", 40);
        check("bp_resume_addr", acc_log[4], 32'hbfc00010);
        out_ready = 1'b0;

        // Redirect with two requests in flight, no responses yet.
        do_reset();
        resp_hold = 1;
        out_ready = 1'b1;
        run_n(6);
        check("two_inflight", acc_log.size(), 2);
        redirect(32'h80001000);
        resp_hold = 0;
        push_seq(32'h80001000, 4);
        run_until_empty("redir_drain", 40);
        check("redir_acc0", acc_log[0], 32'hbfc00000);
        check("redir_acc1", acc_log[1], 32'hbfc00004);
        check("redir_target", acc_log[2], 32'h80001000);

        // Redirect coinciding with an accept and a response; head popped too.
        do_reset();
        out_ready = 1'b1;
        sb.push_back(mk_exp(32'hbfc00000, inst_of(32'hbfc00000), 1'b0));
        n = 0;
        while (acc_log.size() < 2 && n < 20) begin
            cycle();
            n++;
        end
        check("coinc_setup", acc_log.size(), 2);
        redirect(32'h80002000);
        check("coinc_accept", acc_log[2], 32'hbfc00008);
        check("coinc_resp", last_rsp, 1);
        check("coinc_head_popped", hs_cyc.size(), 1);
        push_seq(32'h80002000, 4);
        run_until_empty("coinc_drain", 40);
        check("coinc_target", acc_log[3], 32'h80002000);

        // Redirects while a request waits for addr_ok; the last target wins.
        do_reset();
        out_ready   = 1'b1;
        addr_ok_pct = 0;
        run_n(3);
        redirect(32'h80004000);
        run_n(2);
        redirect(32'h80005000);
        run_n(2);
        addr_ok_pct = 100;
        push_seq(32'h80005000, 4);
        run_until_empty("pend_drain", 40);
        check("pend_held_req", acc_log[0], 32'hbfc00000);
        check("pend_target", acc_log[1], 32'h80005000);

        // Misaligned target: one ADEL entry, then fetch stops until redirect.
        do_reset();
        run_n(6);
        redirect(32'h80000002);
        sb.push_back(mk_exp(32'h80000002, 32'h0, 1'b1));
        n_acc = acc_log.size();
        out_ready = 1'b1;
        run_until_empty("adel_drain", 20);
        run_n(8);
        check("adel_no_fetch", acc_log.size(), n_acc);
        check("adel_en_low", inst_sram_en, 0);
        redirect(32'h80000100);
        push_seq(32'h80000100, 4);
        run_until_empty("adel_resume", 40);
        check("adel_resume_addr", acc_log[n_acc], 32'h80000100);

        // Reset mid-transfer; stale responses must not reach decode.
        resp_hold = 1;
        do_reset();
        redirect(32'h80003000);
        out_ready = 1'b1;
        run_n(4);
        check("mid_inflight", acc_log.size(), 2);
        resetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        resp_hold = 0;
        prev_pend = 0;
        cycle();
        resetn = 1'b1;
        acc_log.delete();
        acc_cyc.delete();
        sb.delete();
        push_seq(32'hbfc00000, 4);
        run_until_empty("post_reset_drain", 40);
        check("post_reset_addr", acc_log[0], 32'hbfc00000);

        // Random bus timing, random back-pressure, random redirects.
        do_reset();
        rand_ready  = 1;
        addr_ok_pct = 70;
        lat_min     = 1;
        lat_max     = 3;
        check_occ   = 1;
        push_seq(32'hbfc00000, 64);
        for (int s = 0; s < 6; s++) begin
            run_n(int'($urandom_range(15, 40)));
            tgt = {$urandom(), 2'b00} >> 0;
            tgt[1:0] = 2'b00;
            redirect(tgt);
            push_seq(tgt, 64);
        end
        run_n(30);
        rand_ready = 0;
        check_occ  = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
